// File: rtl/stage_if_pkg.sv
// Shared widths, NOP encoding and IF FSM state type for the fetch stage.
// STAGE_IF_MISALIGN_CHK_EN adds the ERR state used by the misaligned-target check.
package stage_if_pkg;
   localparam int unsigned DEF_PC_WIDTH       = 32;
   localparam int unsigned DEF_INST_WIDTH     = 32;
   localparam int unsigned DEF_REG_ADDR_WIDTH = 5;
   localparam logic [31:0] NOP_INST           = 32'h0000_0013;

   typedef enum logic [2:0] {
      S_REQ  = 3'd0,
      S_WAIT = 3'd1,
      S_HOLD = 3'd2,
      S_DROP = 3'd3
`ifdef STAGE_IF_MISALIGN_CHK_EN
      ,S_ERR = 3'd4
`endif
   } if_state_t;
endpackage

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: reset > flush > stall (hold) > load > bubble.
// Used by stage_if in every build, including STAGE_IF_MISALIGN_CHK_EN.
module if_id_pipe_reg
   import stage_if_pkg::*;
#(
   parameter int unsigned PC_WIDTH   = DEF_PC_WIDTH,
   parameter int unsigned INST_WIDTH = DEF_INST_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  flush,
   input  logic                  stall,
   input  logic                  load,
   input  logic [PC_WIDTH-1:0]   load_pc,
   input  logic [INST_WIDTH-1:0] load_inst,
   output logic [PC_WIDTH-1:0]   pc,
   output logic [INST_WIDTH-1:0] inst,
   output logic                  valid
);
   localparam logic [INST_WIDTH-1:0] NOP = INST_WIDTH'(NOP_INST);

   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         pc    <= '0;
         inst  <= NOP;
         valid <= 1'b0;
      end else if (!stall) begin
         if (load) begin
            pc    <= load_pc;
            inst  <= load_inst;
            valid <= 1'b1;
         end else begin
            pc    <= '0;
            inst  <= NOP;
            valid <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/stage_if.sv
// RV32I instruction-fetch stage: PC, single-outstanding IMEM handshake, one-entry hold buffer.
// Define STAGE_IF_MISALIGN_CHK_EN to trap misaligned next-PCs into a sticky ERR state.
module stage_if
   import stage_if_pkg::*;
#(
   parameter int unsigned         PC_WIDTH       = DEF_PC_WIDTH,
   parameter int unsigned         INST_WIDTH     = DEF_INST_WIDTH,
   parameter int unsigned         REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
   parameter logic [PC_WIDTH-1:0] RESET_PC       = '0
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      pc_write,
   input  logic                      pc_sel,
   input  logic [PC_WIDTH-1:0]       pc_imm,
   input  logic                      IF_flush,
   output logic                      imem_req,
   output logic [PC_WIDTH-1:0]       imem_addr,
   input  logic                      imem_ready,
   input  logic                      imem_rvalid,
   input  logic [INST_WIDTH-1:0]     imem_rdata,
   output logic [PC_WIDTH-1:0]       IF_ID_pc,
   output logic [INST_WIDTH-1:0]     IF_ID_inst,
   output logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
   output logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
   output logic                      IF_ID_valid,
   output logic                      fetch_misalign
);
   localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

   if_state_t             state, state_nxt;
   logic [PC_WIDTH-1:0]   pc, pc_nxt, req_pc, buf_pc, load_pc;
   logic [INST_WIDTH-1:0] buf_inst, load_inst;
   logic                  redirect, accept, store, load, flush;

   assign redirect  = pc_sel & pc_write;
   assign imem_addr = pc;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
`ifdef STAGE_IF_MISALIGN_CHK_EN
         state    <= (RESET_PC[1:0] != 2'b00) ? S_ERR : S_REQ;
`else
         state    <= S_REQ;
`endif
         pc       <= RESET_PC;
         req_pc   <= '0;
         buf_pc   <= '0;
         buf_inst <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         if (accept) req_pc <= pc;
         if (store) begin
            buf_pc   <= req_pc;
            buf_inst <= imem_rdata;
         end
      end
   end

`ifdef STAGE_IF_MISALIGN_CHK_EN
   logic misalign_set, misalign_q;

   always_ff @(posedge clk) begin
      if (!reset_n)          misalign_q <= (RESET_PC[1:0] != 2'b00);
      else if (misalign_set) misalign_q <= 1'b1;
   end
   assign fetch_misalign = misalign_q;
`else
   assign fetch_misalign = 1'b0;
`endif

   // A redirect overrides every state action; an outstanding response becomes stale (DROP).
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
`ifdef STAGE_IF_MISALIGN_CHK_EN
      misalign_set = 1'b0;
`endif
      case (state)
         S_REQ: begin
            if (redirect) begin
               pc_nxt    = pc_imm;
               state_nxt = imem_ready ? S_DROP : S_REQ;
            end else if (imem_ready) begin
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect) begin
               pc_nxt    = pc_imm;
               state_nxt = imem_rvalid ? S_REQ : S_DROP;
            end else if (imem_rvalid) begin
               if (pc_write) begin
                  pc_nxt    = req_pc + PC_STEP;
                  state_nxt = S_REQ;
               end else begin
                  state_nxt = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (redirect) begin
               pc_nxt    = pc_imm;
               state_nxt = S_REQ;
            end else if (pc_write) begin
               pc_nxt    = buf_pc + PC_STEP;
               state_nxt = S_REQ;
            end
         end
         S_DROP: begin
            if (redirect)    pc_nxt    = pc_imm;
            if (imem_rvalid) state_nxt = S_REQ;
         end
         default: ;
      endcase
`ifdef STAGE_IF_MISALIGN_CHK_EN
      if (state != S_ERR && redirect && pc_imm[1:0] != 2'b00) begin
         state_nxt    = S_ERR;
         misalign_set = 1'b1;
      end
`endif
   end

   always_comb begin
      imem_req  = (state == S_REQ) & reset_n;
      accept    = (state == S_REQ) & imem_ready;
      store     = (state == S_WAIT) & imem_rvalid & ~pc_write;
      load      = ~redirect & pc_write &
                  (((state == S_WAIT) & imem_rvalid) | (state == S_HOLD));
      load_pc   = (state == S_HOLD) ? buf_pc : req_pc;
      load_inst = (state == S_HOLD) ? buf_inst : imem_rdata;
`ifdef STAGE_IF_MISALIGN_CHK_EN
      flush     = IF_flush | (state == S_ERR);
`else
      flush     = IF_flush;
`endif
   end

   if_id_pipe_reg #(
      .PC_WIDTH   (PC_WIDTH),
      .INST_WIDTH (INST_WIDTH)
   ) u_if_id (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .stall     (~pc_write),
      .load      (load),
      .load_pc   (load_pc),
      .load_inst (load_inst),
      .pc        (IF_ID_pc),
      .inst      (IF_ID_inst),
      .valid     (IF_ID_valid)
   );

   assign IF_ID_rs1 = IF_ID_inst[15 +: REG_ADDR_WIDTH];
   assign IF_ID_rs2 = IF_ID_inst[20 +: REG_ADDR_WIDTH];
endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: directed fetch scenarios, then randomized stalls/redirects/flushes
// against a transaction-level model (outstanding-request flags plus a hold queue).
module tb_stage_if;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n, pc_write, pc_sel, IF_flush;
   logic [31:0] pc_imm, imem_addr, imem_rdata, IF_ID_pc, IF_ID_inst;
   logic        imem_req, imem_ready, imem_rvalid, IF_ID_valid, fetch_misalign;
   logic [4:0]  IF_ID_rs1, IF_ID_rs2;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   stage_if #(
      .PC_WIDTH       (32),
      .INST_WIDTH     (32),
      .REG_ADDR_WIDTH (5),
      .RESET_PC       (32'h0000_0000)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .pc_write       (pc_write),
      .pc_sel         (pc_sel),
      .pc_imm         (pc_imm),
      .IF_flush       (IF_flush),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .IF_ID_pc       (IF_ID_pc),
      .IF_ID_inst     (IF_ID_inst),
      .IF_ID_rs1      (IF_ID_rs1),
      .IF_ID_rs2      (IF_ID_rs2),
      .IF_ID_valid    (IF_ID_valid),
      .fetch_misalign (fetch_misalign)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h0050_0093;
         32'h4:   return 32'h00A0_0113;
         32'h8:   return 32'h0020_8233;
         default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- IMEM responder ----------------
   bit          pend = 1'b0;
   int unsigned cnt = 0;
   logic [31:0] paddr = '0;
   int unsigned lat_min = 1, lat_max = 1;
   bit          rand_ready = 1'b0;
   logic        s_req = 1'b0;
   logic [31:0] s_addr = '0;

   task automatic imem_edge();
      if (!reset_n) begin
         pend = 1'b0;
      end else begin
         if (imem_rvalid)           pend = 1'b0;
         else if (pend && cnt != 0) cnt--;
         if (s_req && imem_ready) begin
            pend  = 1'b1;
            paddr = s_addr;
            cnt   = $urandom_range(lat_max, lat_min) - 1;
         end
      end
   endtask

   task automatic imem_drive();
      imem_ready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      imem_rvalid = pend && cnt == 0;
      imem_rdata  = imem_rvalid ? mem_word(paddr) : $urandom;
   endtask

   // ---------------- reference model ----------------
   bit          m_known = 1'b0;
   logic [31:0] m_pc, m_oaddr, m_ifpc, m_ifinst;
   bit          m_out, m_stale, m_ifv, m_err, m_mis;
   logic [63:0] m_buf[$];

   task automatic model_edge();
      bit          redir, req, live, have, from_buf;
      logic [31:0] npc, ninst, old_pc;
      if (!reset_n) begin
         m_known = 1'b1; m_pc = 32'h0; m_oaddr = 32'h0;
         m_out = 1'b0; m_stale = 1'b0; m_buf.delete();
         m_ifpc = 32'h0; m_ifinst = NOP; m_ifv = 1'b0;
         m_err = 1'b0; m_mis = 1'b0;
         return;
      end
      if (!m_known) return;
      old_pc   = m_pc;
      redir    = pc_write && pc_sel;
      req      = !m_err && !m_out && m_buf.size() == 0;
      live     = m_out && !m_stale && imem_rvalid;
      from_buf = m_buf.size() != 0;
      have     = pc_write && !redir && !m_err && (live || from_buf);
      npc      = from_buf ? m_buf[0][63:32] : m_oaddr;
      ninst    = from_buf ? m_buf[0][31:0]  : imem_rdata;

      if (IF_flush || m_err || (pc_write && !have)) begin
         m_ifpc = 32'h0; m_ifinst = NOP; m_ifv = 1'b0;
      end else if (have) begin
         m_ifpc = npc; m_ifinst = ninst; m_ifv = 1'b1;
      end

      if (redir)     m_pc = pc_imm;
      else if (have) m_pc = npc + 32'd4;

      if (redir)                      m_buf.delete();
      else if (have && from_buf)      void'(m_buf.pop_front());
      else if (live && !pc_write)     m_buf.push_back({m_oaddr, imem_rdata});

      if (m_out && imem_rvalid) m_out = 1'b0;
      else if (m_out && redir)  m_stale = 1'b1;
      if (req && imem_ready) begin
         m_out = 1'b1; m_stale = redir; m_oaddr = old_pc;
      end
`ifdef STAGE_IF_MISALIGN_CHK_EN
      if (!m_err && redir && pc_imm[1:0] != 2'b00) begin
         m_err = 1'b1; m_mis = 1'b1;
      end
`endif
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      imem_edge();
      #1;
      imem_drive();
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      logic        exp_req;
      logic [31:0] t;
      s_req  = imem_req;
      s_addr = imem_addr;
      if (m_known) begin
         exp_req = reset_n && !m_err && !m_out && m_buf.size() == 0;
         t       = m_ifinst;
         check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
         if (exp_req) check("imem_addr", imem_addr, m_pc);
         check("IF_ID_valid", {31'b0, IF_ID_valid}, {31'b0, m_ifv});
         check("IF_ID_inst", IF_ID_inst, m_ifinst);
         if (m_ifv) check("IF_ID_pc", IF_ID_pc, m_ifpc);
         check("IF_ID_rs1", {27'b0, IF_ID_rs1}, {27'b0, t[19:15]});
         check("IF_ID_rs2", {27'b0, IF_ID_rs2}, {27'b0, t[24:20]});
         check("fetch_misalign", {31'b0, fetch_misalign}, {31'b0, m_mis});
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      reset_n = 1'b0; pc_write = 1'b1; pc_sel = 1'b0; pc_imm = '0; IF_flush = 1'b0;
      imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

      step();
      check("T1 req in reset", {31'b0, imem_req}, 32'd0);
      check("T1 inst in reset", IF_ID_inst, NOP);
      step();
      reset_n = 1'b1;
      #1;
      check("T1 req", {31'b0, imem_req}, 32'd1);
      check("T1 addr", imem_addr, 32'h0);
      check("T1 inst", IF_ID_inst, NOP);
      check("T1 valid", {31'b0, IF_ID_valid}, 32'd0);

      step(); step();
      check("T2 pc0", IF_ID_pc, 32'h0);
      check("T2 inst0", IF_ID_inst, 32'h0050_0093);
      check("T2 rs1", {27'b0, IF_ID_rs1}, 32'd0);
      check("T2 rs2 first", {27'b0, IF_ID_rs2}, 32'd5);
      check("T2 valid0", {31'b0, IF_ID_valid}, 32'd1);
      step();
      check("T2 bubble", {31'b0, IF_ID_valid}, 32'd0);
      step();
      check("T2 pc1", IF_ID_pc, 32'h4);
      check("T2 rs2 second", {27'b0, IF_ID_rs2}, 32'd10);
      check("T2 next addr", imem_addr, 32'h8);

      step();
      pc_write = 1'b0;
      step();
      check("T3 held valid", {31'b0, IF_ID_valid}, 32'd0);
      check("T3 held inst", IF_ID_inst, NOP);
      check("T3 no req in HOLD", {31'b0, imem_req}, 32'd0);
      pc_write = 1'b1;
      step();
      check("T3 inst", IF_ID_inst, 32'h0020_8233);
      check("T3 pc", IF_ID_pc, 32'h8);
      check("T3 addr", imem_addr, 32'hC);

      lat_min = 2; lat_max = 2;
      step();
      pc_sel = 1'b1; pc_imm = 32'h100; IF_flush = 1'b1;
      step();
      pc_sel = 1'b0; IF_flush = 1'b0;
      lat_min = 1; lat_max = 1;
      check("T4 flushed inst", IF_ID_inst, NOP);
      check("T4 flushed valid", {31'b0, IF_ID_valid}, 32'd0);
      check("T4 no req in DROP", {31'b0, imem_req}, 32'd0);
      step();
      check("T4 req", {31'b0, imem_req}, 32'd1);
      check("T4 addr", imem_addr, 32'h100);
      step(); step();
      check("T4 fetched pc", IF_ID_pc, 32'h100);

      pc_sel = 1'b1; pc_imm = 32'hFFFF_FFFC;
      step();
      pc_sel = 1'b0;
      step();
      check("T5 addr top", imem_addr, 32'hFFFF_FFFC);
      step(); step();
      check("T5 pc top", IF_ID_pc, 32'hFFFF_FFFC);
      check("T5 wrap addr", imem_addr, 32'h0);

      pc_sel = 1'b1; pc_imm = 32'h102;
      step();
      pc_sel = 1'b0;
      step();
`ifdef STAGE_IF_MISALIGN_CHK_EN
      check("T6 misalign", {31'b0, fetch_misalign}, 32'd1);
      check("T6 req off", {31'b0, imem_req}, 32'd0);
      step();
      check("T6 err valid", {31'b0, IF_ID_valid}, 32'd0);
`else
      check("T6 misalign", {31'b0, fetch_misalign}, 32'd0);
      check("T6 addr", imem_addr, 32'h102);
      step(); step();
      check("T6 fetched pc", IF_ID_pc, 32'h102);
`endif

      reset_n = 1'b0;
      step();
      reset_n = 1'b1; rand_ready = 1'b1; lat_min = 1; lat_max = 3;
      for (int i = 0; i < 3000; i++) begin
         pc_write = ($urandom_range(0, 3) != 0);
         pc_sel   = ($urandom_range(0, 9) == 0);
         pc_imm   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2))
                                                 : (32'($urandom_range(0, 255)) << 2);
         IF_flush = ($urandom_range(0, 11) == 0);
         reset_n  = (i != 1500);
         step();
      end
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
